// File: rtl/sub32_pkg.sv
// Shared constants and types for the nibble-serial 32-bit subtractor.
package sub32_pkg;

  localparam int W   = 32;
  localparam int NIB = 4;
  localparam int CNT_W = $clog2(W / NIB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub4_bla.sv
// Combinational 4-bit borrow-lookahead subtractor slice: dn = an - bn - bin.
module sub4_bla (
  input  logic [3:0] an,
  input  logic [3:0] bn,
  input  logic       bin,
  output logic [3:0] dn,
  output logic       bout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] br;

  // A bit borrows on its own when 0-1; it passes an incoming borrow when the bits are equal.
  assign g = ~an & bn;
  assign p = ~(an ^ bn);

  assign br[0] = bin;
  assign br[1] = g[0] | (p[0] & bin);
  assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bin);
  assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

  assign dn   = an ^ bn ^ br[3:0];
  assign bout = br[4];

endmodule

// File: rtl/sub32_nsr.sv
// Nibble-serial subtractor: one 4-bit borrow-lookahead slice reused over N_NIB cycles.
// Handshake: start is accepted only in IDLE; done pulses for one cycle and results hold until the next completion.
module sub32_nsr
  import sub32_pkg::*;
#(
  parameter int N_NIB = W / NIB
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bo,
  output logic         ov,
  output logic         z,
  output state_t       dbg_state
);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       a_sh;
  logic [W-1:0]       b_sh;
  logic [W-1:0]       d_sh;
  logic [W-1:0]       d_nx;
  logic               brw;
  logic               a_msb;
  logic               b_msb;
  logic [NIB-1:0]     dn;
  logic               bout;
  logic               last;

  sub4_bla u_slice (
    .an   (a_sh[NIB-1:0]),
    .bn   (b_sh[NIB-1:0]),
    .bin  (brw),
    .dn   (dn),
    .bout (bout)
  );

  assign last = (cnt == CNT_W'(N_NIB - 1));
  assign d_nx = {dn, d_sh[W-1:NIB]};

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN) || (state == DONE);
    done      = (state == DONE);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      brw   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      d     <= '0;
      bo    <= 1'b0;
      ov    <= 1'b0;
      z     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          brw   <= bi;
          cnt   <= '0;
          a_msb <= a[W-1];
          b_msb <= b[W-1];
        end
        RUN: begin
          a_sh <= a_sh >> NIB;
          b_sh <= b_sh >> NIB;
          brw  <= bout;
          cnt  <= cnt + 1'b1;
          d_sh <= d_nx;
          // The final slice supplies the top nibble, so flags are taken from d_nx directly.
          if (last) begin
            d  <= d_nx;
            bo <= bout;
            ov <= (a_msb ^ b_msb) & (dn[NIB-1] ^ a_msb);
            z  <= (d_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub32_nsr.sv
// Directed and randomized checks of sub32_nsr against hand values and a 33-bit subtraction model.
module tb_sub32_nsr;
  import sub32_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  a = '0;
  logic [31:0]  b = '0;
  logic         bi = 1'b0;
  logic         busy;
  logic         done;
  logic [31:0]  d;
  logic         bo;
  logic         ov;
  logic         z;
  state_t       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [34:0] exp_q[$];

  sub32_nsr dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .busy      (busy),
    .done      (done),
    .d         (d),
    .bo        (bo),
    .ov        (ov),
    .z         (z),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed expectation {bo, ov, z, d} from a plain 33-bit subtraction.
  function automatic logic [34:0] model(input logic [31:0] av, input logic [31:0] bv, input logic biv);
    logic [32:0] r;
    logic        o;
    r = {1'b0, av} - {1'b0, bv} - {32'd0, biv};
    o = (av[31] ^ bv[31]) & (r[31] ^ av[31]);
    return {r[32], o, (r[31:0] == 32'd0), r[31:0]};
  endfunction

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic biv, input logic [34:0] exp);
    int n;
    a = av; b = bv; bi = biv; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; bi = 1'($urandom_range(0, 1));
    check({tag, "_busy"}, busy, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_d"}, d, exp[31:0]);
    check({tag, "_bo"}, bo, exp[34]);
    check({tag, "_ov"}, ov, exp[33]);
    check({tag, "_z"}, z, exp[32]);
    tick();
    check({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int dones;
    logic [34:0] e;

    // Reset state
    tick(); tick();
    check("rst_state", dbg_state, IDLE);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_flags", {d, bo, ov, z}, 35'd0);
    reset_n = 1'b1;
    tick();

    // Directed vectors: {bo, ov, z, d} hand-computed
    run_op("v_5m3",   32'h00000005, 32'h00000003, 1'b0, {1'b0, 1'b0, 1'b0, 32'h00000002});
    run_op("v_0m1",   32'h00000000, 32'h00000001, 1'b0, {1'b1, 1'b0, 1'b0, 32'hFFFFFFFF});
    run_op("v_ovf",   32'h80000000, 32'h00000001, 1'b0, {1'b0, 1'b1, 1'b0, 32'h7FFFFFFF});
    run_op("v_zero",  32'h00000010, 32'h0000000F, 1'b1, {1'b0, 1'b0, 1'b1, 32'h00000000});
    run_op("v_full",  32'h00000000, 32'hFFFFFFFF, 1'b1, {1'b1, 1'b0, 1'b1, 32'h00000000});
    run_op("v_negov", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, {1'b1, 1'b1, 1'b0, 32'h80000000});

    // Reset at nibble 4 aborts the operation
    a = 32'hDEADBEEF; b = 32'h01234567; bi = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_busy_done", {busy, done}, 2'b00);
    check("abort_outputs", {d, bo, ov, z}, 35'd0);
    check("abort_state", dbg_state, IDLE);
    dones = 0;
    repeat (12) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op("v_after_abort", 32'h12345678, 32'h02345678, 1'b0, {1'b0, 1'b0, 1'b0, 32'h10000000});

    // Start held high with operands changing every cycle: accept every 10th edge
    dones = 0;
    start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      a = $urandom; b = $urandom; bi = 1'($urandom_range(0, 1));
      if (i % 10 == 0) exp_q.push_back(model(a, b, bi));
      tick();
      check("cont_done_timing", done, (i % 10 == 8));
      if (done === 1'b1) begin
        dones++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("cont_result", {bo, ov, z, d}, e);
        end
      end
    end
    start = 1'b0;
    tick();
    check("cont_dones", dones, 5);
    check("cont_idle", busy, 1'b0);

    // Randomized operands against the model, biased toward edge values
    for (int i = 0; i < 500; i++) begin
      logic [31:0] av, bv;
      logic biv;
      av = (i % 7 == 0) ? 32'hFFFFFFFF : $urandom;
      bv = (i % 11 == 0) ? 32'hFFFFFFFF : ((i % 13 == 0) ? av : $urandom);
      biv = 1'($urandom_range(0, 1));
      run_op("rand", av, bv, biv, model(av, bv, biv));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
